// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute controller: drives PC select/write, fetch handshake, ALU strobe.
// Define PC_SEQ_INSTR_CNT_EN to enable the retired-instruction counter on instr_count.
module pc_sequencer #(
    parameter int INSTR_W = 12,
    parameter int OP_W    = 4,
    parameter int ADDR_W  = 6,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               zero_flag,
    output logic               ir_we,
    output logic               pc_sel,
    output logic               pc_we,
    output logic [ADDR_W-1:0]  pc_offset,
    output logic               alu_en,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_BEQZ = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(4'hF);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [OP_W-1:0]    opcode;

    assign opcode = ir[INSTR_W-1 -: OP_W];

    // Bits between the opcode and offset fields carry no meaning here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_we)
                ir <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        ir_we     = 1'b0;
        pc_sel    = 1'b0;
        pc_we     = 1'b0;
        pc_offset = '0;
        alu_en    = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                // Capture strobe follows the ack within the cycle; reset abandons it.
                if (mem_ack && !rst) begin
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                busy      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                pc_we     = 1'b1;
                pc_offset = ir[ADDR_W-1:0];
                pc_sel    = 1'b1;
                state_nxt = FETCH;
                case (opcode)
                    OP_NOP:  ;
                    OP_ALU:  alu_en = 1'b1;
                    OP_BEQZ: pc_sel = ~zero_flag;
                    OP_JMP:  pc_sel = 1'b0;
                    OP_HLT:  state_nxt = HALT;
                    default: illegal = 1'b1;
                endcase
            end
            HALT: begin
                halted = 1'b1;
                if (start)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PC_SEQ_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Every EXEC retires one instruction, HLT and illegal opcodes included.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == EXEC)
            cnt <= cnt + CNT_W'(1);
    end

    assign instr_count = cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one linear stimulus sequence with immediate assertions.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, mem_ack, zero_flag;
    logic [11:0] mem_rdata;
    logic        mem_req, ir_we, pc_sel, pc_we, alu_en, busy, halted, illegal;
    logic [5:0]  pc_offset;
    logic [7:0]  instr_count;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .zero_flag(zero_flag), .ir_we(ir_we), .pc_sel(pc_sel), .pc_we(pc_we),
        .pc_offset(pc_offset), .alu_en(alu_en), .busy(busy), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in a FETCH cycle: acks immediately, walks through DECODE, returns in EXEC.
    task automatic fetch(input logic [11:0] instr);
        mem_ack   = 1'b1;
        mem_rdata = instr;
        #1 chk("fetch_ir_we", 32'(ir_we), 1);
        chk("fetch_mem_req", 32'(mem_req), 1);
        step();
        mem_ack = 1'b0;
        #1 chk("decode_pc_we", 32'(pc_we), 0);
        chk("decode_mem_req", 32'(mem_req), 0);
        chk("decode_ir_we", 32'(ir_we), 0);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_cnt", 32'(instr_count), 0);

        // NOP with immediate ack
        rst = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("nop_fetch_busy", 32'(busy), 1);
        fetch(12'h000);
        #1 chk("nop_pc_we", 32'(pc_we), 1);
        chk("nop_pc_sel", 32'(pc_sel), 1);
        chk("nop_alu_en", 32'(alu_en), 0);
        chk("nop_illegal", 32'(illegal), 0);
        step();
        chk("nop_next_fetch", 32'(mem_req), 1);

        // ALU with three wait cycles before ack
        for (int i = 0; i < 3; i++) begin
            #1 chk("alu_wait_req", 32'(mem_req), 1);
            chk("alu_wait_ir_we", 32'(ir_we), 0);
            step();
        end
        fetch(12'h100);
        #1 chk("alu_alu_en", 32'(alu_en), 1);
        chk("alu_pc_sel", 32'(pc_sel), 1);
        chk("alu_pc_we", 32'(pc_we), 1);
        step();

        // BEQZ, both flag values in the same EXEC cycle
        fetch(12'h205);
        zero_flag = 1'b1;
        #1 chk("beqz_z1_pc_sel", 32'(pc_sel), 0);
        chk("beqz_offset", 32'(pc_offset), 5);
        chk("beqz_z1_pc_we", 32'(pc_we), 1);
        zero_flag = 1'b0;
        #1 chk("beqz_z0_pc_sel", 32'(pc_sel), 1);
        chk("beqz_z0_pc_we", 32'(pc_we), 1);
        step();
        chk("beqz_next_offset", 32'(pc_offset), 0);

        // JMP with maximal offset
        fetch(12'h33F);
        #1 chk("jmp_pc_sel", 32'(pc_sel), 0);
        chk("jmp_offset", 32'(pc_offset), 32'h3F);
        chk("jmp_pc_we", 32'(pc_we), 1);
        step();

        // HLT, then resume
        fetch(12'hF00);
        #1 chk("hlt_pc_we", 32'(pc_we), 1);
        chk("hlt_pc_sel", 32'(pc_sel), 1);
        step();
        chk("halt_halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_mem_req", 32'(mem_req), 0);
        chk("halt_pc_we", 32'(pc_we), 0);
        mem_ack = 1'b1;
        #1 chk("halt_ack_ignored", 32'(ir_we), 0);
        mem_ack = 1'b0;
        step();
        chk("halt_stays", 32'(halted), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume_mem_req", 32'(mem_req), 1);
        chk("resume_halted", 32'(halted), 0);

        // Undefined opcode behaves as NOP with an illegal pulse
        fetch(12'h700);
        #1 chk("ill_illegal", 32'(illegal), 1);
        chk("ill_pc_sel", 32'(pc_sel), 1);
        chk("ill_pc_we", 32'(pc_we), 1);
        chk("ill_alu_en", 32'(alu_en), 0);
        step();
        chk("ill_pulse_end", 32'(illegal), 0);
`ifdef PC_SEQ_INSTR_CNT_EN
        chk("cnt_six", 32'(instr_count), 6);
`else
        chk("cnt_off", 32'(instr_count), 0);
`endif

        // Reset mid-fetch with a pending ack
        chk("pre_rst_mem_req", 32'(mem_req), 1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 12'h100;
        #1 chk("rst_ack_abandon", 32'(ir_we), 0);
        step();
        chk("rst2_mem_req", 32'(mem_req), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_cnt", 32'(instr_count), 0);
        rst = 1'b0; mem_ack = 1'b0;
        step();
        chk("idle_hold_req", 32'(mem_req), 0);
        chk("idle_hold_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
